// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer and imem.
// master = sequencer side, slave = memory side.
interface pc_fetch_sequencer_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// PC owner and fetch sequencer: picks next PC, drives req/ack fetch to imem.
// Optional target alignment check enabled by PC_SEQ_ALIGN_CHECK_EN.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
    parameter int unsigned STEP         = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall_i,
    input  logic                        branch_taken_i,
    input  logic [31:0]                 branch_target_i,
    input  logic                        jump_i,
    input  logic [31:0]                 jump_target_i,
    input  logic                        exc_i,
    pc_fetch_sequencer_if.master        imem,
    output logic [31:0]                 pc_o,
    output logic                        pc_valid_o,
    output logic                        misalign_o
);
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] STEP_W     = 32'(STEP);

    localparam logic [1:0] P_NONE   = 2'd0;
    localparam logic [1:0] P_BRANCH = 2'd1;
    localparam logic [1:0] P_JUMP   = 2'd2;
    localparam logic [1:0] P_EXC    = 2'd3;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_HOLD
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [1:0]  pend_pri;
    logic [31:0] pend_tgt;
    logic        req_q;
    logic        mis_q;

    logic [31:0] br_tgt;
    logic [31:0] jp_tgt;
    logic        br_bad;
    logic        jp_bad;
    logic [1:0]  in_pri;
    logic [31:0] in_tgt;
    logic        in_mis;
    logic        take;
    logic        eff_valid;
    logic [1:0]  eff_pri;
    logic [31:0] eff_tgt;
    logic [31:0] next_pc;

    assign imem.imem_req_o  = req_q;
    assign imem.imem_addr_o = pc;
    assign misalign_o       = mis_q;

    always_comb begin
        br_tgt = branch_target_i & ALIGN_MASK;
        jp_tgt = jump_target_i & ALIGN_MASK;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        br_bad = branch_taken_i && (branch_target_i[1:0] != 2'b00);
        jp_bad = jump_i && (jump_target_i[1:0] != 2'b00);
`else
        br_bad = 1'b0;
        jp_bad = 1'b0;
`endif
        in_pri = P_NONE;
        in_tgt = EXC_VECTOR;
        in_mis = 1'b0;
        // misaligned targets turn into exceptions, so they outrank real jumps
        if (exc_i) begin
            in_pri = P_EXC;
        end else if (jp_bad || br_bad) begin
            in_pri = P_EXC;
            in_mis = 1'b1;
        end else if (jump_i) begin
            in_pri = P_JUMP;
            in_tgt = jp_tgt;
        end else if (branch_taken_i) begin
            in_pri = P_BRANCH;
            in_tgt = br_tgt;
        end

        take      = (in_pri != P_NONE) && (in_pri >= pend_pri);
        eff_valid = (in_pri != P_NONE) || (pend_pri != P_NONE);
        eff_pri   = take ? in_pri : pend_pri;
        eff_tgt   = take ? in_tgt : pend_tgt;
        next_pc   = (eff_pri != P_NONE) ? eff_tgt : pc + STEP_W;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_BOOT;
            pc         <= RESET_VECTOR;
            pend_pri   <= P_NONE;
            pend_tgt   <= '0;
            req_q      <= 1'b0;
            pc_o       <= '0;
            pc_valid_o <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            pc_valid_o <= 1'b0;
            mis_q      <= take && in_mis;
            case (state)
                S_BOOT, S_HOLD: begin
                    pend_pri <= P_NONE;
                    if (eff_valid) begin
                        pc <= eff_tgt;
                    end
                    if (stall_i) begin
                        state <= S_HOLD;
                        req_q <= 1'b0;
                    end else begin
                        state <= S_REQ;
                        req_q <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (imem.imem_ack_i) begin
                        pc       <= next_pc;
                        pend_pri <= P_NONE;
                        // any redirect seen during this fetch kills it
                        if (!eff_valid) begin
                            pc_o       <= pc;
                            pc_valid_o <= 1'b1;
                        end
                        if (stall_i) begin
                            state <= S_HOLD;
                            req_q <= 1'b0;
                        end else begin
                            state <= S_REQ;
                            req_q <= 1'b1;
                        end
                    end else begin
                        pend_pri <= eff_pri;
                        pend_tgt <= eff_tgt;
                    end
                end
                default: begin
                    state <= S_BOOT;
                    req_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with a pc_o scoreboard.
// Expected misalign behaviour follows PC_SEQ_ALIGN_CHECK_EN.
module tb_pc_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        exc_i;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        misalign_o;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mis_addr;

    pc_fetch_sequencer_if imem ();

    pc_fetch_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .exc_i           (exc_i),
        .imem            (imem.master),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
        .misalign_o      (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] addr);
        chk("fetch_req", 32'(imem.imem_req_o), 32'd1);
        chk("fetch_addr", imem.imem_addr_o, addr);
        imem.imem_ack_i = 1'b1;
        exp_q.push_back(addr);
        tick();
        imem.imem_ack_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (pc_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_valid", pc_o, 32'hDEAD_BEEF);
            end else begin
                chk("sb_pc", pc_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        stall_i = 1'b0;
        branch_taken_i = 1'b0;
        branch_target_i = '0;
        jump_i = 1'b0;
        jump_target_i = '0;
        exc_i = 1'b0;
        imem.imem_ack_i = 1'b0;
        tick();
        tick();
        chk("rst_req", 32'(imem.imem_req_o), 32'd0);
        chk("rst_addr", imem.imem_addr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_valid", 32'(pc_valid_o), 32'd0);
        chk("rst_mis", 32'(misalign_o), 32'd0);

        rst_n = 1'b1;
        tick();
        chk("boot_req", 32'(imem.imem_req_o), 32'd1);
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);

        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", 32'(imem.imem_req_o), 32'd1);
            chk("stall_addr", imem.imem_addr_o, 32'hC);
            tick();
        end
        fetch(32'hC);
        chk("hold_req", 32'(imem.imem_req_o), 32'd0);
        tick();
        chk("hold_req2", 32'(imem.imem_req_o), 32'd0);
        chk("hold_addr", imem.imem_addr_o, 32'h10);
        stall_i = 1'b0;
        tick();
        chk("unhold_req", 32'(imem.imem_req_o), 32'd1);

        branch_taken_i = 1'b1;
        branch_target_i = 32'h400;
        tick();
        branch_taken_i = 1'b0;
        chk("br_addr_held", imem.imem_addr_o, 32'h10);
        imem.imem_ack_i = 1'b1;
        tick();
        imem.imem_ack_i = 1'b0;
        chk("br_squash", 32'(pc_valid_o), 32'd0);
        chk("br_addr", imem.imem_addr_o, 32'h400);

        imem.imem_ack_i = 1'b1;
        branch_taken_i = 1'b1;
        branch_target_i = 32'h800;
        tick();
        imem.imem_ack_i = 1'b0;
        branch_taken_i = 1'b0;
        chk("br_ack_squash", 32'(pc_valid_o), 32'd0);
        chk("br_ack_addr", imem.imem_addr_o, 32'h800);

        exc_i = 1'b1;
        jump_i = 1'b1;
        jump_target_i = 32'h1000;
        tick();
        exc_i = 1'b0;
        jump_i = 1'b0;
        imem.imem_ack_i = 1'b1;
        tick();
        imem.imem_ack_i = 1'b0;
        chk("exc_addr", imem.imem_addr_o, 32'h180);
        fetch(32'h180);

        jump_i = 1'b1;
        jump_target_i = 32'h2000;
        tick();
        jump_i = 1'b0;
        branch_taken_i = 1'b1;
        branch_target_i = 32'h3000;
        tick();
        branch_taken_i = 1'b0;
        imem.imem_ack_i = 1'b1;
        tick();
        imem.imem_ack_i = 1'b0;
        chk("drop_low_addr", imem.imem_addr_o, 32'h2000);

        jump_i = 1'b1;
        jump_target_i = 32'hFFFF_FFFC;
        imem.imem_ack_i = 1'b1;
        tick();
        jump_i = 1'b0;
        imem.imem_ack_i = 1'b0;
        chk("wrap_pre", imem.imem_addr_o, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC);
        chk("wrap_addr", imem.imem_addr_o, 32'h0);

        jump_i = 1'b1;
        jump_target_i = 32'h402;
        tick();
        jump_i = 1'b0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
        chk("mis_pulse", 32'(misalign_o), 32'd1);
        mis_addr = 32'h180;
`else
        chk("mis_pulse", 32'(misalign_o), 32'd0);
        mis_addr = 32'h400;
`endif
        imem.imem_ack_i = 1'b1;
        tick();
        imem.imem_ack_i = 1'b0;
        chk("mis_clear", 32'(misalign_o), 32'd0);
        chk("mis_addr", imem.imem_addr_o, mis_addr);

        stall_i = 1'b1;
        fetch(mis_addr);
        branch_taken_i = 1'b1;
        branch_target_i = 32'h500;
        tick();
        branch_taken_i = 1'b0;
        chk("hold_br_req", 32'(imem.imem_req_o), 32'd0);
        chk("hold_br_addr", imem.imem_addr_o, 32'h500);
        stall_i = 1'b0;
        tick();
        fetch(32'h500);

        rst_n = 1'b0;
        imem.imem_ack_i = 1'b1;
        tick();
        imem.imem_ack_i = 1'b0;
        chk("rst_mid_valid", 32'(pc_valid_o), 32'd0);
        chk("rst_mid_req", 32'(imem.imem_req_o), 32'd0);
        chk("rst_mid_addr", imem.imem_addr_o, 32'h0);
        rst_n = 1'b1;
        tick();
        fetch(32'h0);
        chk("restart_next", imem.imem_addr_o, 32'h4);

        tick();
        tick();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
